// File: rtl/ysyx_22050710_csr_pkg.sv
// Shared constants for the machine-mode CSR unit: addresses, cause codes,
// mstatus field positions and write-op encodings.
package ysyx_22050710_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;

   localparam int unsigned ECALL_M    = 11;
   localparam int unsigned BREAKPOINT = 3;
   localparam int unsigned MTI        = 7;

   localparam int unsigned MST_MIE    = 3;
   localparam int unsigned MST_MPIE   = 7;
   localparam int unsigned MST_MPP_LO = 11;
   localparam int unsigned MST_MPP_HI = 12;
   localparam int unsigned MIE_MTIE   = 7;
   localparam int unsigned MIP_MTIP   = 7;

   typedef enum logic [1:0] {
      WOP_NONE  = 2'b00,
      WOP_WRITE = 2'b01,
      WOP_SET   = 2'b10,
      WOP_CLEAR = 2'b11
   } wop_e;

endpackage

// File: rtl/ysyx_22050710_csr_trap.sv
// Combinational trap sequencing: resolves interrupt/ecall/ebreak/mret priority
// and produces the redirect target plus next mepc/mcause/mstatus.
module ysyx_22050710_csr_trap
   import ysyx_22050710_csr_pkg::*;
#(
   parameter int unsigned XLEN        = 64,
   parameter bit          VECTORED_EN = 1'b1
) (
   input  logic            i_commit,
   input  logic            i_timer_irq,
   input  logic            i_ecall,
   input  logic            i_ebreak,
   input  logic            i_mret,
   input  logic            i_mtie,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_mstatus,
   input  logic [XLEN-1:0] i_mtvec,
   input  logic [XLEN-1:0] i_mepc,
   output logic            o_trap,
   output logic            o_mret,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_nextpc,
   output logic [XLEN-1:0] o_mepc,
   output logic [XLEN-1:0] o_mcause,
   output logic [XLEN-1:0] o_mstatus
);

   logic            irq;
   logic [XLEN-1:0] base;

   assign irq  = i_mstatus[MST_MIE] & i_mtie & i_timer_irq & i_commit;
   assign base = {i_mtvec[XLEN-1:2], 2'b00};

   always_comb begin
      o_trap     = irq | i_ecall | i_ebreak;
      o_mret     = i_mret & ~o_trap;
      o_redirect = o_trap | o_mret;
      o_nextpc   = '0;
      o_mepc     = i_pc;
      o_mcause   = '0;
      o_mstatus  = i_mstatus;
      if (irq) begin
         o_mepc   = i_pc + XLEN'(4);
         o_mcause = {1'b1, (XLEN-1)'(MTI)};
      end else if (i_ecall) begin
         o_mcause = XLEN'(ECALL_M);
      end else if (i_ebreak) begin
         o_mcause = XLEN'(BREAKPOINT);
      end
      if (o_trap) begin
         o_mstatus[MST_MPIE]              = i_mstatus[MST_MIE];
         o_mstatus[MST_MIE]               = 1'b0;
         o_mstatus[MST_MPP_HI:MST_MPP_LO] = 2'b11;
         // Only timer interrupts are vectored; exceptions always go to base.
         if (irq && VECTORED_EN && i_mtvec[1:0] == 2'b01)
            o_nextpc = base + XLEN'(4 * MTI);
         else
            o_nextpc = base;
      end else if (o_mret) begin
         o_mstatus[MST_MIE]               = i_mstatus[MST_MPIE];
         o_mstatus[MST_MPIE]              = 1'b1;
         o_mstatus[MST_MPP_HI:MST_MPP_LO] = 2'b11;
         o_nextpc                         = i_mepc;
      end
   end

endmodule

// File: rtl/ysyx_22050710_csr_unit.sv
// Machine-mode CSR file with trap entry/return, counters and a registered
// PC redirect toward the fetch unit.
module ysyx_22050710_csr_unit
   import ysyx_22050710_csr_pkg::*;
#(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter bit          VECTORED_EN = 1'b1,
   parameter logic [63:0] MSTATUS_RST = 64'ha00001800
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   input  logic                  i_ren,
   output logic [XLEN-1:0]       o_rdata,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [XLEN-1:0]       i_wdata,
   input  logic [1:0]            i_wop,
   output logic                  o_illegal,
   input  logic                  i_ecall,
   input  logic                  i_ebreak,
   input  logic                  i_mret,
   input  logic                  i_commit,
   input  logic [XLEN-1:0]       i_pc,
   input  logic                  i_timer_irq,
   output logic [XLEN-1:0]       o_nextpc,
   output logic                  o_redirect
);

   localparam logic [ADDR_WIDTH-1:0] A_MSTATUS  = ADDR_WIDTH'(CSR_MSTATUS);
   localparam logic [ADDR_WIDTH-1:0] A_MIE      = ADDR_WIDTH'(CSR_MIE);
   localparam logic [ADDR_WIDTH-1:0] A_MTVEC    = ADDR_WIDTH'(CSR_MTVEC);
   localparam logic [ADDR_WIDTH-1:0] A_MSCRATCH = ADDR_WIDTH'(CSR_MSCRATCH);
   localparam logic [ADDR_WIDTH-1:0] A_MEPC     = ADDR_WIDTH'(CSR_MEPC);
   localparam logic [ADDR_WIDTH-1:0] A_MCAUSE   = ADDR_WIDTH'(CSR_MCAUSE);
   localparam logic [ADDR_WIDTH-1:0] A_MTVAL    = ADDR_WIDTH'(CSR_MTVAL);
   localparam logic [ADDR_WIDTH-1:0] A_MIP      = ADDR_WIDTH'(CSR_MIP);
   localparam logic [ADDR_WIDTH-1:0] A_MCYCLE   = ADDR_WIDTH'(CSR_MCYCLE);
   localparam logic [ADDR_WIDTH-1:0] A_MINSTRET = ADDR_WIDTH'(CSR_MINSTRET);

   // MIE/MPIE are software-writable; MPP is hard-wired to machine mode.
   localparam logic [XLEN-1:0] MST_WMASK = XLEN'((64'd1 << MST_MIE) | (64'd1 << MST_MPIE));
   localparam logic [XLEN-1:0] MST_MPP   = XLEN'(64'h1800);

   logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
   logic [XLEN-1:0] mtval_q, mtval_d, mcycle_q, mcycle_d, minstret_q, minstret_d;
   logic [XLEN-1:0] nextpc_q, mip;
   logic            redirect_q;

   logic            t_trap, t_mret, t_redirect;
   logic [XLEN-1:0] t_nextpc, t_mepc, t_mcause, t_mstatus;
   logic [XLEN-1:0] rmux, wold, wv;
   logic            r_impl, w_impl, csr_we;

   assign mip = XLEN'(i_timer_irq) << MIP_MTIP;

   ysyx_22050710_csr_trap #(.XLEN(XLEN), .VECTORED_EN(VECTORED_EN)) u_trap (
      .i_commit    (i_commit),
      .i_timer_irq (i_timer_irq),
      .i_ecall     (i_ecall),
      .i_ebreak    (i_ebreak),
      .i_mret      (i_mret),
      .i_mtie      (mie_q[MIE_MTIE]),
      .i_pc        (i_pc),
      .i_mstatus   (mstatus_q),
      .i_mtvec     (mtvec_q),
      .i_mepc      (mepc_q),
      .o_trap      (t_trap),
      .o_mret      (t_mret),
      .o_redirect  (t_redirect),
      .o_nextpc    (t_nextpc),
      .o_mepc      (t_mepc),
      .o_mcause    (t_mcause),
      .o_mstatus   (t_mstatus)
   );

   always_comb begin
      rmux   = '0;
      r_impl = 1'b1;
      case (i_raddr)
         A_MSTATUS:  rmux = mstatus_q;
         A_MIE:      rmux = mie_q;
         A_MTVEC:    rmux = mtvec_q;
         A_MSCRATCH: rmux = mscratch_q;
         A_MEPC:     rmux = mepc_q;
         A_MCAUSE:   rmux = mcause_q;
         A_MTVAL:    rmux = mtval_q;
         A_MIP:      rmux = mip;
         A_MCYCLE:   rmux = mcycle_q;
         A_MINSTRET: rmux = minstret_q;
         default:    r_impl = 1'b0;
      endcase
   end

   always_comb begin
      wold   = '0;
      w_impl = 1'b1;
      case (i_waddr)
         A_MSTATUS:  wold = mstatus_q;
         A_MIE:      wold = mie_q;
         A_MTVEC:    wold = mtvec_q;
         A_MSCRATCH: wold = mscratch_q;
         A_MEPC:     wold = mepc_q;
         A_MCAUSE:   wold = mcause_q;
         A_MTVAL:    wold = mtval_q;
         A_MIP:      wold = mip;
         A_MCYCLE:   wold = mcycle_q;
         A_MINSTRET: wold = minstret_q;
         default:    w_impl = 1'b0;
      endcase
   end

   always_comb begin
      case (wop_e'(i_wop))
         WOP_WRITE: wv = i_wdata;
         WOP_SET:   wv = wold | i_wdata;
         WOP_CLEAR: wv = wold & ~i_wdata;
         default:   wv = wold;
      endcase
   end

   assign o_rdata   = i_ren ? rmux : '0;
   assign o_illegal = (i_ren & ~r_impl) | ((i_wop != WOP_NONE) & ~w_impl);
   // Any trap or mret in the same cycle swallows the CSR write.
   assign csr_we    = (i_wop != WOP_NONE) & ~t_redirect;

   always_comb begin
      mstatus_d  = mstatus_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      mcycle_d   = mcycle_q + XLEN'(1);
      minstret_d = minstret_q + XLEN'(i_commit);
      if (t_trap) begin
         mstatus_d = t_mstatus;
         mepc_d    = t_mepc;
         mcause_d  = t_mcause;
         mtval_d   = '0;
      end else if (t_mret) begin
         mstatus_d = t_mstatus;
      end else if (csr_we) begin
         case (i_waddr)
            A_MSTATUS:  mstatus_d = (mstatus_q & ~MST_WMASK) | (wv & MST_WMASK) | MST_MPP;
            A_MIE:      mie_d[MIE_MTIE] = wv[MIE_MTIE];
            A_MTVEC:    mtvec_d    = wv & ~XLEN'(2);
            A_MSCRATCH: mscratch_d = wv;
            A_MEPC:     mepc_d     = wv & ~XLEN'(3);
            A_MCAUSE:   mcause_d   = wv;
            A_MTVAL:    mtval_d    = wv;
            A_MCYCLE:   mcycle_d   = wv;
            A_MINSTRET: minstret_d = wv;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mstatus_q  <= MSTATUS_RST[XLEN-1:0];
         mie_q      <= '0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
         nextpc_q   <= '0;
         redirect_q <= 1'b0;
      end else begin
         mstatus_q  <= mstatus_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
         nextpc_q   <= t_nextpc;
         redirect_q <= t_redirect;
      end
   end

   assign o_nextpc   = nextpc_q;
   assign o_redirect = redirect_q;

endmodule

// File: doc/ysyx_22050710_csr_unit.md
Name: ysyx_22050710_csr_unit

Overview:
Parametrised machine-mode CSR file with trap sequencing. It replaces the single-ecall CSR block.
- Implements the CSRRW/CSRRS/CSRRC write modes.
- Handles ecall/ebreak/timer-interrupt entry, mret return, and direct/vectored mtvec.
- Maintains free-running mcycle and minstret counters.
- Sits beside the regfile in EXU/WB; drives a registered PC-redirect to IFU.

Parameters:
XLEN, 64, data width of every CSR and PC (32 or 64)
ADDR_WIDTH, 12, CSR address width
VECTORED_EN, 1, 1 = honour mtvec.MODE=01 vectored interrupts; 0 = treat MODE as direct
MSTATUS_RST, 64'ha00001800, reset value of mstatus (truncated to XLEN)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_raddr  in  ADDR_WIDTH  CSR read address
i_ren  in  1  read enable
o_rdata  out  XLEN  read data; 0 when i_ren=0 or address unimplemented
i_waddr  in  ADDR_WIDTH  CSR write address
i_wdata  in  XLEN  write operand (rs1 or zimm, zero-extended)
i_wop  in  2  00 none, 01 write, 10 set, 11 clear
o_illegal  out  1  access (i_ren or i_wop!=0) to unimplemented address, combinational
i_ecall  in  1  ecall retiring this cycle
i_ebreak  in  1  ebreak retiring this cycle
i_mret  in  1  mret retiring this cycle
i_commit  in  1  an instruction retires this cycle (instruction boundary)
i_pc  in  XLEN  PC of retiring instruction
i_timer_irq  in  1  machine timer interrupt level
o_nextpc  out  XLEN  redirect target, registered
o_redirect  out  1  one-cycle redirect pulse, registered

Behaviour:
- Implemented CSRs: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mcycle B00, minstret B02.
- All other addresses: read 0, writes ignored, o_illegal=1.
- Reset (async, i_rst_n=0) values:
  - mstatus=MSTATUS_RST; all other CSRs 0.
  - o_nextpc=0, o_redirect=0.
- Read: combinational from current state. Same-cycle writes are not visible until the next cycle.
- Write, effective at the clock edge:
  - 01: csr = wdata.
  - 10: csr = csr | wdata.
  - 11: csr = csr & ~wdata.
  - Per-CSR masks:
    - mepc[1:0] forced 0.
    - mtvec[1] forced 0.
    - mip read-only: bit7 = i_timer_irq, other bits 0, writes ignored.
    - mie: only bit7 (MTIE) writable.
    - mstatus: only MIE(3), MPIE(7) and MPP(12:11) writable; MPP writes always store 2'b11.
- Interrupt pending when all of mstatus.MIE=1, mie.MTIE=1, i_timer_irq=1, i_commit=1.
- Event priority per cycle: interrupt > ecall > ebreak > mret > CSR write. A lower-priority event in the same cycle is dropped entirely.
- Trap entry (interrupt, ecall or ebreak):
  - mepc: interrupt stores i_pc+4; ecall and ebreak store i_pc.
  - mcause:
    - interrupt: {1'b1, (XLEN-1)'d7}
    - ecall: 11
    - ebreak: 3
  - mtval=0.
  - mstatus: MPIE<=MIE, MIE<=0, MPP<=11.
  - o_nextpc <= {mtvec[XLEN-1:2],2'b00}, plus 4*7 if the event is an interrupt, VECTORED_EN=1 and mtvec[1:0]=01.
  - o_redirect<=1.
- mret:
  - o_nextpc<=mepc, o_redirect<=1.
  - mstatus: MIE<=MPIE, MPIE<=1, MPP<=11.
- Redirect timing: o_redirect is high exactly the cycle after the event and returns to 0 unless another event occurs. o_nextpc is 0 whenever o_redirect=0.
- Counters:
  - mcycle increments every cycle out of reset.
  - minstret increments when i_commit=1.
  - Both wrap modulo 2^XLEN.
  - A CSR write to a counter in the same cycle wins over its increment.
- Reset mid-trap clears any pending o_redirect immediately (async).

Decomposition:
- Shared package ysyx_22050710_csr_pkg holds:
  - CSR address constants.
  - Cause codes (ECALL_M=11, BREAKPOINT=3, MTI=7).
  - mstatus bit positions.
  - wop encodings.
- One natural sub-module: ysyx_22050710_csr_trap. It does priority resolution and computes the target PC and the mcause/mepc/mstatus next values. It is combinational; its outputs are registered in the parent.

Test Plan:
- Reset, then read 300 and 342 -> 64'ha00001800 and 0; read 7C0 -> o_rdata=0, o_illegal=1.
- Write 305=0x80001000; ecall at i_pc=0x80000100 -> next cycle: o_redirect=1, o_nextpc=0x80001000; then mepc=0x80000100, mcause=11, mstatus.MIE=0.
- Set mstatus.MIE and mie.MTIE, mtvec=0x80001001, i_timer_irq=1, i_commit=1, i_pc=0x200 -> o_nextpc=0x8000101C; mepc=0x204; mcause MSB=1, low bits=7.
- mret after trap with MPIE=1 -> o_nextpc=mepc, mstatus.MIE=1, MPIE=1.
- Same cycle: ecall + CSR write 340=0xDEAD -> mscratch unchanged, ecall taken. Then 10-op 0xF0 then 11-op 0x30 on mscratch=0 -> 0xC0.
- Preload mcycle=all-ones via write -> the next read shows 0 (wrap). Assert i_rst_n low mid-redirect -> o_redirect=0 immediately.
